// File: rtl/aqp_ovl_wr_arbiter.sv
// Overlay write arbiter.
// Two requesters share the text, font and palette RAM write ports. Grants are
// combinational in IDLE (round-robin under contention). A fill engine can take
// over the text port and write one latched word to all 1024 text locations.
// Every accepted write or fill write is registered onto the ovl_* outputs.

module aqp_ovl_wr_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    input  logic [1:0]  req0_sel,
    input  logic [10:0] req0_addr,
    input  logic [15:0] req0_wrdata,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [1:0]  req1_sel,
    input  logic [10:0] req1_addr,
    input  logic [15:0] req1_wrdata,
    output logic        req1_ready,

    input  logic        fill_start,
    input  logic [15:0] fill_data,
    output logic        fill_busy,
    output logic        fill_done,

    output logic [9:0]  ovl_text_addr,
    output logic [15:0] ovl_text_wrdata,
    output logic        ovl_text_wr,

    output logic [10:0] ovl_font_addr,
    output logic [7:0]  ovl_font_wrdata,
    output logic        ovl_font_wr,

    output logic [3:0]  ovl_palette_addr,
    output logic [15:0] ovl_palette_wrdata,
    output logic        ovl_palette_wr
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam logic [1:0] SEL_TEXT    = 2'd0;
    localparam logic [1:0] SEL_FONT    = 2'd1;
    localparam logic [1:0] SEL_PALETTE = 2'd2;

    localparam logic [9:0] FILL_LAST = 10'h3FF;

    // Control state
    logic [0:0]  state_q,      state_d;
    logic [9:0]  counter_q,    counter_d;
    logic [15:0] fill_word_q,  fill_word_d;
    logic        last_grant_q, last_grant_d;
    logic        fill_done_q,  fill_done_d;

    // Registered write ports
    logic [9:0]  text_addr_q,  text_addr_d;
    logic [15:0] text_data_q,  text_data_d;
    logic        text_wr_q,    text_wr_d;
    logic [10:0] font_addr_q,  font_addr_d;
    logic [7:0]  font_data_q,  font_data_d;
    logic        font_wr_q,    font_wr_d;
    logic [3:0]  pal_addr_q,   pal_addr_d;
    logic [15:0] pal_data_q,   pal_data_d;
    logic        pal_wr_q,     pal_wr_d;

    // Grant and the selected (accepted) transfer
    logic        grant0;
    logic        grant1;
    logic        acc_valid;
    logic [1:0]  acc_sel;
    logic [10:0] acc_addr;
    logic [15:0] acc_data;

    // Grant decision: only in IDLE; under contention the requester not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Mux the granted requester's transfer; grant implies valid, so a grant is a transfer.
    always_comb begin
        acc_valid = grant0 || grant1;
        acc_sel   = req0_sel;
        acc_addr  = req0_addr;
        acc_data  = req0_wrdata;
        if (grant1) begin
            acc_sel  = req1_sel;
            acc_addr = req1_addr;
            acc_data = req1_wrdata;
        end
    end

    // Round-robin history only moves on a completed transfer, including reserved-select drops.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant1) begin
            last_grant_d = 1'b1;
        end else if (grant0) begin
            last_grant_d = 1'b0;
        end
    end

    // IDLE/FILL sequencing; fill_start is only honoured in IDLE so a running fill is never restarted.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        fill_word_d = fill_word_q;
        fill_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    fill_word_d = fill_data;
                    counter_d   = 10'd0;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                counter_d = counter_q + 10'd1;
                if (counter_q == FILL_LAST) begin
                    // Registered together with the final text write so both appear in the same cycle.
                    fill_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-port next values: addresses/data hold unless a strobe is issued.
    always_comb begin
        text_addr_d = text_addr_q;
        text_data_d = text_data_q;
        text_wr_d   = 1'b0;
        font_addr_d = font_addr_q;
        font_data_d = font_data_q;
        font_wr_d   = 1'b0;
        pal_addr_d  = pal_addr_q;
        pal_data_d  = pal_data_q;
        pal_wr_d    = 1'b0;
        if (state_q == ST_FILL) begin
            text_addr_d = counter_q;
            text_data_d = fill_word_q;
            text_wr_d   = 1'b1;
        end else if (acc_valid) begin
            case (acc_sel)
                SEL_TEXT: begin
                    text_addr_d = acc_addr[9:0];
                    text_data_d = acc_data;
                    text_wr_d   = 1'b1;
                end
                SEL_FONT: begin
                    font_addr_d = acc_addr;
                    font_data_d = acc_data[7:0];
                    font_wr_d   = 1'b1;
                end
                SEL_PALETTE: begin
                    pal_addr_d = acc_addr[3:0];
                    pal_data_d = acc_data;
                    pal_wr_d   = 1'b1;
                end
                default: begin
                    // Reserved target: accepted but silently dropped.
                end
            endcase
        end
    end

    // Control registers; reset aborts any fill and lets requester 0 win the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            counter_q    <= 10'd0;
            fill_word_q  <= 16'd0;
            last_grant_q <= 1'b1;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            fill_word_q  <= fill_word_d;
            last_grant_q <= last_grant_d;
            fill_done_q  <= fill_done_d;
        end
    end

    // Write-port registers; one cycle between acceptance and the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            text_addr_q <= 10'd0;
            text_data_q <= 16'd0;
            text_wr_q   <= 1'b0;
            font_addr_q <= 11'd0;
            font_data_q <= 8'd0;
            font_wr_q   <= 1'b0;
            pal_addr_q  <= 4'd0;
            pal_data_q  <= 16'd0;
            pal_wr_q    <= 1'b0;
        end else begin
            text_addr_q <= text_addr_d;
            text_data_q <= text_data_d;
            text_wr_q   <= text_wr_d;
            font_addr_q <= font_addr_d;
            font_data_q <= font_data_d;
            font_wr_q   <= font_wr_d;
            pal_addr_q  <= pal_addr_d;
            pal_data_q  <= pal_data_d;
            pal_wr_q    <= pal_wr_d;
        end
    end

    assign fill_busy          = (state_q == ST_FILL);
    assign fill_done          = fill_done_q;
    assign ovl_text_addr      = text_addr_q;
    assign ovl_text_wrdata    = text_data_q;
    assign ovl_text_wr        = text_wr_q;
    assign ovl_font_addr      = font_addr_q;
    assign ovl_font_wrdata    = font_data_q;
    assign ovl_font_wr        = font_wr_q;
    assign ovl_palette_addr   = pal_addr_q;
    assign ovl_palette_wrdata = pal_data_q;
    assign ovl_palette_wr     = pal_wr_q;

endmodule

// File: tb/tb_aqp_ovl_wr_arbiter.sv
// Directed bench for the overlay write arbiter.
module tb_aqp_ovl_wr_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [1:0]  req0_sel, req1_sel;
    logic [10:0] req0_addr, req1_addr;
    logic [15:0] req0_wrdata, req1_wrdata;
    logic        req0_ready, req1_ready;
    logic        fill_start;
    logic [15:0] fill_data;
    logic        fill_busy, fill_done;
    logic [9:0]  ovl_text_addr;
    logic [15:0] ovl_text_wrdata;
    logic        ovl_text_wr;
    logic [10:0] ovl_font_addr;
    logic [7:0]  ovl_font_wrdata;
    logic        ovl_font_wr;
    logic [3:0]  ovl_palette_addr;
    logic [15:0] ovl_palette_wrdata;
    logic        ovl_palette_wr;

    int tests_run = 0;
    int tests_failed = 0;

    aqp_ovl_wr_arbiter dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req0_valid         (req0_valid),
        .req0_sel           (req0_sel),
        .req0_addr          (req0_addr),
        .req0_wrdata        (req0_wrdata),
        .req0_ready         (req0_ready),
        .req1_valid         (req1_valid),
        .req1_sel           (req1_sel),
        .req1_addr          (req1_addr),
        .req1_wrdata        (req1_wrdata),
        .req1_ready         (req1_ready),
        .fill_start         (fill_start),
        .fill_data          (fill_data),
        .fill_busy          (fill_busy),
        .fill_done          (fill_done),
        .ovl_text_addr      (ovl_text_addr),
        .ovl_text_wrdata    (ovl_text_wrdata),
        .ovl_text_wr        (ovl_text_wr),
        .ovl_font_addr      (ovl_font_addr),
        .ovl_font_wrdata    (ovl_font_wrdata),
        .ovl_font_wr        (ovl_font_wr),
        .ovl_palette_addr   (ovl_palette_addr),
        .ovl_palette_wrdata (ovl_palette_wrdata),
        .ovl_palette_wr     (ovl_palette_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_no_strobes(input string tag);
        check(tag, {29'd0, ovl_text_wr, ovl_font_wr, ovl_palette_wr}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        int fill_bad;
        reset_n     = 1'b0;
        req0_valid  = 1'b0; req0_sel = 2'd0; req0_addr = 11'd0; req0_wrdata = 16'd0;
        req1_valid  = 1'b0; req1_sel = 2'd0; req1_addr = 11'd0; req1_wrdata = 16'd0;
        fill_start  = 1'b0;
        fill_data   = 16'd0;

        // Reset state
        #2;
        check("rst_strobes", {29'd0, ovl_text_wr, ovl_font_wr, ovl_palette_wr}, 32'd0);
        check("rst_busy_done", {30'd0, fill_busy, fill_done}, 32'd0);
        check("rst_text_addr_data", {6'd0, ovl_text_addr, ovl_text_wrdata}, 32'd0);
        check("rst_font_pal", {1'd0, ovl_font_addr, ovl_font_wrdata, ovl_palette_addr, 8'd0}, 32'd0);
        check("rst_pal_data", {16'd0, ovl_palette_wrdata}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        tick();
        check_no_strobes("first_edge_after_reset");

        // Single text write
        req0_valid = 1'b1; req0_sel = 2'd0; req0_addr = 11'h005; req0_wrdata = 16'h1F41;
        #1;
        check("single_ready", {30'd0, req0_ready, req1_ready}, 32'b10);
        tick();
        req0_valid = 1'b0;
        check("single_text_wr", {31'd0, ovl_text_wr}, 32'd1);
        check("single_text_addr", {22'd0, ovl_text_addr}, 32'h005);
        check("single_text_data", {16'd0, ovl_text_wrdata}, 32'h1F41);
        check("single_other_wr", {30'd0, ovl_font_wr, ovl_palette_wr}, 32'd0);
        tick();
        check("single_strobe_one_cycle", {31'd0, ovl_text_wr}, 32'd0);
        check("single_addr_hold", {6'd0, ovl_text_addr, ovl_text_wrdata}, {6'd0, 10'h005, 16'h1F41});

        // Contention after reset: 0,1,0,1
        do_reset();
        tick();
        req0_valid = 1'b1; req0_sel = 2'd0; req0_addr = 11'h010; req0_wrdata = 16'hA000;
        req1_valid = 1'b1; req1_sel = 2'd2; req1_addr = 11'h001; req1_wrdata = 16'hB000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("contend_grant_%0d", i), {30'd0, req0_ready, req1_ready},
                  (i % 2 == 0) ? 32'b10 : 32'b01);
            tick();
            check($sformatf("contend_strobe_%0d", i), {29'd0, ovl_text_wr, ovl_font_wr, ovl_palette_wr},
                  (i % 2 == 0) ? 32'b100 : 32'b001);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("contend_pal_addr_data", {12'd0, ovl_palette_addr, ovl_palette_wrdata}, {12'd0, 4'h1, 16'hB000});

        // Font write then palette write from requester 1
        tick();
        req1_valid = 1'b1; req1_sel = 2'd1; req1_addr = 11'h7FF; req1_wrdata = 16'hABCD;
        #1;
        check("font_ready", {30'd0, req0_ready, req1_ready}, 32'b01);
        tick();
        check("font_strobe", {29'd0, ovl_text_wr, ovl_font_wr, ovl_palette_wr}, 32'b010);
        check("font_addr_data", {13'd0, ovl_font_addr, ovl_font_wrdata}, {13'd0, 11'h7FF, 8'hCD});
        req1_sel = 2'd2; req1_addr = 11'h01F; req1_wrdata = 16'h1234;
        tick();
        req1_valid = 1'b0;
        check("pal_strobe", {29'd0, ovl_text_wr, ovl_font_wr, ovl_palette_wr}, 32'b001);
        check("pal_addr_data", {12'd0, ovl_palette_addr, ovl_palette_wrdata}, {12'd0, 4'hF, 16'h1234});
        check("text_hold_after_pal", {22'd0, ovl_text_addr}, 32'h010);

        // Reserved select: accepted, dropped, still moves round-robin
        tick();
        req0_valid = 1'b1; req0_sel = 2'd3; req0_addr = 11'h002; req0_wrdata = 16'hDEAD;
        #1;
        check("rsvd_ready", {30'd0, req0_ready, req1_ready}, 32'b10);
        tick();
        check_no_strobes("rsvd_no_strobe");
        req0_sel = 2'd0;
        req1_valid = 1'b1; req1_sel = 2'd2; req1_addr = 11'h003; req1_wrdata = 16'h0042;
        #1;
        check("rsvd_then_req1_first", {30'd0, req0_ready, req1_ready}, 32'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rsvd_then_pal_strobe", {29'd0, ovl_text_wr, ovl_font_wr, ovl_palette_wr}, 32'b001);

        // Fill with a concurrent req0 write
        tick();
        req0_valid = 1'b1; req0_sel = 2'd0; req0_addr = 11'h003; req0_wrdata = 16'h5555;
        fill_start = 1'b1; fill_data = 16'h0720;
        #1;
        check("fill_start_req0_ready", {30'd0, req0_ready, req1_ready}, 32'b10);
        tick();
        fill_start = 1'b0;
        fill_data  = 16'hFFFF;
        check("fill_req0_write_first", {5'd0, ovl_text_wr, ovl_text_addr, ovl_text_wrdata},
              {5'd0, 1'b1, 10'h003, 16'h5555});
        check("fill_busy_on", {31'd0, fill_busy}, 32'd1);
        req1_valid = 1'b1; req1_sel = 2'd0;
        #1;
        check("fill_ready_low", {30'd0, req0_ready, req1_ready}, 32'b00);
        fill_bad = 0;
        for (int k = 0; k < 1024; k++) begin
            tick();
            if (ovl_text_wr !== 1'b1 || ovl_text_addr !== 10'(k) || ovl_text_wrdata !== 16'h0720)
                fill_bad++;
            if (ovl_font_wr !== 1'b0 || ovl_palette_wr !== 1'b0)
                fill_bad++;
            if (fill_done !== (k == 1023))
                fill_bad++;
            if (fill_busy !== (k != 1023))
                fill_bad++;
            if (k != 1023 && (req0_ready !== 1'b0 || req1_ready !== 1'b0))
                fill_bad++;
            if (k == 300) fill_start = 1'b1;
            if (k == 301) fill_start = 1'b0;
            if (k == 1023) begin
                check("fill_last_write_addr", {22'd0, ovl_text_addr}, 32'h3FF);
                check("fill_done_with_last", {30'd0, fill_done, ovl_text_wr}, 32'b11);
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        check("fill_sequence_errors", 32'(fill_bad), 32'd0);
        tick();
        check("fill_after_end", {29'd0, fill_done, fill_busy, ovl_text_wr}, 32'd0);

        // Reset in the middle of a fill
        fill_start = 1'b1; fill_data = 16'h1111;
        tick();
        fill_start = 1'b0;
        repeat (500) tick();
        check("midfill_running", {5'd0, ovl_text_wr, ovl_text_addr, ovl_text_wrdata},
              {5'd0, 1'b1, 10'd499, 16'h1111});
        reset_n = 1'b0;
        #1;
        check("midfill_rst_busy", {30'd0, fill_busy, fill_done}, 32'd0);
        check_no_strobes("midfill_rst_strobes");
        check("midfill_rst_addr", {6'd0, ovl_text_addr, ovl_text_wrdata}, 32'd0);
        #2;
        reset_n = 1'b1;
        req0_valid = 1'b1; req0_sel = 2'd0; req0_addr = 11'h07A; req0_wrdata = 16'h2222;
        req1_valid = 1'b1; req1_sel = 2'd1; req1_addr = 11'h07B; req1_wrdata = 16'h3333;
        #1;
        check("midfill_post_rst_grant", {30'd0, req0_ready, req1_ready}, 32'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("midfill_post_rst_write", {5'd0, ovl_text_wr, ovl_text_addr, ovl_text_wrdata},
              {5'd0, 1'b1, 10'h07A, 16'h2222});
        check("midfill_post_rst_idle", {31'd0, fill_busy}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aqp_ovl_wr_arbiter.md
AQP_OVL_WR_ARBITER -- requirements
Module: aqp_ovl_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset.
REQ-002 clk  input  1  clock for the overlay write domain; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 reqN_valid (N=0,1)  input  1  requester N presents a write.
REQ-005 reqN_sel  input  2  target of the write: 0 text, 1 font, 2 palette, 3 reserved.
REQ-006 reqN_addr  input  11  write address.
REQ-007 reqN_wrdata  input  16  write data.
REQ-008 reqN_ready  output  1  grant; a transfer occurs when reqN_valid and reqN_ready are both high.
REQ-009 fill_start  input  1  one-cycle pulse that starts a text RAM fill.
REQ-010 fill_data  input  16  word written by the fill; sampled on the fill_start cycle.
REQ-011 fill_busy  output  1  high while the fill runs.
REQ-012 fill_done  output  1  one-cycle pulse after the last fill write.
REQ-013 ovl_text_addr  output  10 / ovl_text_wrdata  output  16 / ovl_text_wr  output  1.
REQ-014 ovl_font_addr  output  11 / ovl_font_wrdata  output  8 / ovl_font_wr  output  1.
REQ-015 ovl_palette_addr  output  4 / ovl_palette_wrdata  output  16 / ovl_palette_wr  output  1.

Function
REQ-016 The block SHALL have two states: IDLE and FILL.
REQ-017 In IDLE with a single valid requester, that requester SHALL be granted combinationally in the same cycle.
REQ-018 In IDLE with both requesters valid, the grant SHALL be round-robin: the requester not granted last wins, and last_grant updates only on a completed transfer.
REQ-019 In FILL, both reqN_ready outputs SHALL be 0.
REQ-020 An accepted write SHALL appear on the ovl_* outputs one cycle after acceptance, with exactly one of the three wr strobes high for one cycle.
REQ-021 Write address and data mapping: text takes addr[9:0] and wrdata[15:0]; font takes addr[10:0] and wrdata[7:0]; palette takes addr[3:0] and wrdata[15:0].
REQ-022 A write with sel=3 SHALL be accepted and dropped: no wr strobe, and it still counts as a grant for round-robin.
REQ-023 Addr/wrdata outputs SHALL hold their last values when no strobe is active.
REQ-024 fill_start in IDLE SHALL latch fill_data, clear a 10-bit counter, and enter FILL on the next edge.
REQ-025 If fill_start and a requester valid occur in the same IDLE cycle, the requester SHALL still be granted that cycle, and FILL begins next cycle.
REQ-026 In FILL, each cycle SHALL issue one text write at address = counter with the latched data, then increment the counter.
REQ-027 After address 1023 is written, the block SHALL return to IDLE and pulse fill_done; the 1024 writes SHALL be contiguous, and the last ovl_text_wr and fill_done SHALL be in the same cycle.
REQ-028 fill_start during FILL SHALL be ignored: no restart and no data relatch.
REQ-029 fill_busy SHALL be high exactly while in the FILL state.

Reset
REQ-030 Asserting reset_n low SHALL immediately force the following, aborting any fill in progress:
- state = IDLE;
- counter = 0;
- last_grant = 1, so requester 0 wins the first contention;
- all wr strobes, fill_busy and fill_done = 0;
- all ovl addr/wrdata outputs = 0.
REQ-031 No write SHALL be issued on the first rising edge after reset_n deasserts unless a request was accepted in that cycle.

Verification
REQ-032 Single write: req0 presents sel=0, addr=0x005, data=0x1F41 -> ready high in the same cycle; one cycle later ovl_text_wr=1, addr=0x005, data=0x1F41.
REQ-033 Contention after reset: both requesters held valid for 4 cycles -> grants in order 0,1,0,1, with strobes following one cycle later in the same order.
REQ-034 Font and palette writes: req1 sel=1, addr=0x7FF, data=0xABCD -> ovl_font_wr with addr 0x7FF, data 0xCD; sel=2, addr=0x1F -> ovl_palette_wr with addr 0xF.
REQ-035 Fill: fill_start with fill_data=0x0720 while req0 is valid -> req0 write first; then 1024 consecutive text writes at addresses 0..1023 with data 0x0720; ready low throughout; fill_done coincident with the address-1023 write; a second fill_start mid-fill is ignored.
REQ-036 Reserved select: req0 sel=3 -> ready high, no strobe; a following contention grants req1 first.
REQ-037 Reset mid-fill: reset_n low at counter=500 -> fill_busy=0 and strobes=0 immediately; after release, the first contention grants req0.
